zoom_uart_rx: RTL and testbench

//   Serial receive front end feeding the tt_um_zoom_zoom datapath from one input pin.

---
 rtl/zoom_uart_rx.sv | 124 ++++++++++++
 tb/tb_zoom_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/zoom_uart_rx.sv
// Oversampled 8N1 UART receiver with a two-flop line synchroniser and a one-entry
// valid/ready holding register, reporting framing errors and overruns as one-cycle pulses.
module zoom_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned CycW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
    localparam logic [CycW-1:0] CycHalf = CycW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q;
    logic                 sync1_q, sync2_q;
    logic [CycW-1:0]      cyc_q;
    logic [IdxW-1:0]      idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cyc_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // A delivery in StStop below overrides this consume.
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cyc_q   <= '0;
                    end
                end
                StStart: begin
                    if (cyc_q == CycHalf) begin
                        cyc_q <= '0;
                        idx_q <= '0;
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StData: begin
                    if (cyc_q == CycLast) begin
                        cyc_q          <= '0;
                        shreg_q[idx_q] <= rx_s;
                        if (idx_q == IdxLast) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cyc_q == CycLast) begin
                        cyc_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                            if (!rx_valid_q || rx_ready_i) begin
                                rx_data_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_zoom_uart_rx.sv
// Directed self-checking bench for zoom_uart_rx at CLKS_PER_BIT=8, DATA_BITS=8.
module tb_zoom_uart_rx;

    localparam int unsigned Cpb = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vld_cnt = 0;
    logic [7:0] last_data = 8'h00;
    int fe_base, ov_base, vld_base;

    zoom_uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .DATA_BITS   (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Pulse/cycle counters sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid) begin
            vld_cnt++;
            last_data = rx_data;
        end
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        fe_base  = fe_cnt;
        ov_base  = ov_cnt;
        vld_base = vld_cnt;
    endtask

    // Start bit plus data bits; caller is just after a rising edge.
    task automatic send_head(input logic [7:0] d);
        rx = 1'b0;
        repeat (Cpb) wait_clk();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (Cpb) wait_clk();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_head(d);
        rx = stop;
        repeat (Cpb) wait_clk();
        rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) wait_clk();
        check("reset_data", {24'h0, rx_data}, 32'h0);
        check("reset_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_ferr", {31'h0, frame_err}, 32'h0);
        check("reset_ovr", {31'h0, overrun}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (5) wait_clk();

        // 1: clean 0xA5 with consumer ready
        rx_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        repeat (10) wait_clk();
        check("t1_valid_cycles", vld_cnt - vld_base, 1);
        check("t1_data", {24'h0, last_data}, 32'hA5);
        check("t1_ferr", fe_cnt - fe_base, 0);
        check("t1_ovr", ov_cnt - ov_base, 0);
        check("t1_busy", {31'h0, busy}, 32'h0);

        // 2: 3-cycle glitch rejected at mid start bit
        snap();
        rx = 1'b0;
        repeat (3) wait_clk();
        rx = 1'b1;
        wait_clk();
        check("t2_busy_mid", {31'h0, busy}, 32'h1);
        repeat (20) wait_clk();
        check("t2_busy_end", {31'h0, busy}, 32'h0);
        check("t2_valid", vld_cnt - vld_base, 0);
        check("t2_ferr", fe_cnt - fe_base, 0);

        // 3: framing error, line held low, then recovery
        snap();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) wait_clk();
        check("t3_ferr_pulse", fe_cnt - fe_base, 1);
        check("t3_valid", vld_cnt - vld_base, 0);
        check("t3_busy_break", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        repeat (10) wait_clk();
        check("t3_busy_idle", {31'h0, busy}, 32'h0);
        snap();
        send_frame(8'h55, 1'b1);
        repeat (10) wait_clk();
        check("t3_next_valid", vld_cnt - vld_base, 1);
        check("t3_next_data", {24'h0, last_data}, 32'h55);

        // 4: overrun on back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) wait_clk();
        check("t4_ovr_pulse", ov_cnt - ov_base, 1);
        check("t4_valid_held", {31'h0, rx_valid}, 32'h1);
        check("t4_data_held", {24'h0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        wait_clk();
        check("t4_valid_drop", {31'h0, rx_valid}, 32'h0);

        // 5: consume and load on the same edge
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        repeat (10) wait_clk();
        check("t5_first_data", {24'h0, rx_data}, 32'h11);
        send_head(8'h22);
        rx = 1'b1;
        repeat (Cpb - 2) wait_clk();
        rx_ready = 1'b1;
        wait_clk();
        rx_ready = 1'b0;
        check("t5_valid", {31'h0, rx_valid}, 32'h1);
        check("t5_data", {24'h0, rx_data}, 32'h22);
        check("t5_ovr", ov_cnt - ov_base, 0);
        repeat (3) wait_clk();
        check("t5_still_held", {24'h0, rx_data}, 32'h22);

        // 6: reset mid-frame discards frame and held byte
        rx = 1'b0;
        repeat (Cpb) wait_clk();
        rx = 1'b1;
        repeat (20) wait_clk();
        check("t6_busy_pre", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        wait_clk();
        check("t6_rst_data", {24'h0, rx_data}, 32'h0);
        check("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_rst_ferr", {31'h0, frame_err}, 32'h0);
        check("t6_rst_ovr", {31'h0, overrun}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (5) wait_clk();
        rx_ready = 1'b1;
        snap();
        send_frame(8'h0F, 1'b1);
        repeat (10) wait_clk();
        check("t6_valid", vld_cnt - vld_base, 1);
        check("t6_data", {24'h0, last_data}, 32'h0F);
        check("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
